decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode stage with a valid/ready output register; it is the producer side of the ALU operation interface.
- Accepts a fetched instruction and PC, reads the register file through combinational read ports, and registers the fields the execute stage needs: alu_op (shared codes header encodings), op_a, op_b, immediate and control flags.
- Detects load-use hazards against the instruction held in its output register and inserts one bubble.

Parameters:
HAZARD_CHECK, 1, 1 enables load-use bubble insertion; 0 disables it (in_ready ignores hazard)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of held/incoming instruction
in_valid  in  1  instruction available
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction address
rs1_addr  out  5  in_instr[19:15], combinational
rs2_addr  out  5  in_instr[24:20], combinational
rs1_data  in  32  regfile read data, write-through
rs2_data  in  32  regfile read data, write-through
out_valid  out  1  output register holds an instruction
out_ready  in  1  execute stage accepts
out_pc  out  32  registered pc
alu_op  out  4  ALU operation code
op_a  out  32  ALU operand a
op_b  out  32  ALU operand b
use_cond  out  1  result is cond zero-extended (SLT/SLTU)
imm  out  32  sign-extended immediate for branch/jump/memory target
store_data  out  32  rs2 value for stores
rd  out  5  destination register
reg_we  out  1  writeback enable, forced 0 when rd==0
is_load, is_store, is_branch, is_jal, is_jalr  out  1 each  class flags
mem_funct3  out  3  instr[14:12], width/sign for memory
illegal  out  1  unsupported encoding

Behaviour:
- Reset: out_valid=0; all registered outputs 0.
- Handshake:
  - fire_in = in_valid && in_ready; fire_out = out_valid && out_ready.
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Output register update:
  - fire_in: load the decoded instruction, out_valid<=1.
  - else fire_out: out_valid<=0.
  - else hold all outputs stable (no change while out_valid && !out_ready).
- Hazard: hazard = HAZARD_CHECK && in_valid && out_valid && is_load && rd!=0 && ((uses_rs1 && rs1_addr==rd) || (uses_rs2 && rs2_addr==rd)).
  - uses_rs1: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: OP, STORE, BRANCH.
  - A hazard with fire_out gives exactly one bubble cycle (out_valid=0); the dependent instruction is accepted the next cycle.
- Flush: out_valid<=0 next cycle; no input accepted in the flush cycle. rst has priority over flush.
- Latency: one cycle from fire_in to out_valid.
- Decode by opcode:
  - OP (0110011), a=rs1, b=rs2:
    - funct3/funct7 map: 000/00 ADD; 000/20 SUB; 001/00 SLL (b=rs2[4:0] zero-ext); 010/00 LT use_cond; 011/00 LTU use_cond; 100/00 XOR; 101/00 SRL; 101/20 SRA (b=rs2[4:0]); 110/00 OR; 111/00 AND.
    - Any other funct7 is illegal.
  - OP-IMM (0010011), a=rs1, b=I-imm, same funct3 map:
    - Shifts use b=instr[24:20] zero-ext; SLLI requires funct7=00; SRLI/SRAI select on funct7 00/20, else illegal.
  - LUI: ADD, a=0, b=U-imm.
  - AUIPC: ADD, a=pc, b=U-imm.
  - JAL: ADD, a=pc, b=4, imm=J-imm, is_jal.
  - JALR: ADD, a=pc, b=4, imm=I-imm, is_jalr; funct3!=000 is illegal.
  - BRANCH: a=rs1, b=rs2, imm=B-imm, reg_we=0, is_branch.
    - funct3 map: 000 EQ; 001 NE; 100 LT; 101 GE; 110 LTU; 111 GEU; 010/011 illegal.
  - LOAD: ADD, a=rs1, b=I-imm, is_load; funct3 must be in {000,001,010,100,101}.
  - STORE: ADD, a=rs1, b=S-imm, store_data=rs2, reg_we=0, is_store; funct3 must be ≤010.
- reg_we=1 only for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD with rd!=0.
- Illegal instruction (incl. unknown opcode, FENCE, SYSTEM): still passes through with out_valid=1 and illegal=1; reg_we, all class flags, alu_op, op_a and op_b are 0; out_pc is valid.
- Immediates are sign-extended from bit 31 per RV32I formats; no arithmetic is performed in this stage.

Test Plan:
- Reset then in_instr=0x00208033 (add x0,x1,x2), rs1=5, rs2=7 -> next cycle out_valid=1, alu_op=ADD, op_a=5, op_b=7, rd=0, reg_we=0.
- Instr 0x4020D1B3 (sra x3,x1,x2), rs2_data=0xFFFFFF23 -> alu_op=SRA, op_b=3, reg_we=1; slti 0xFFF0A193 -> alu_op=LT, use_cond=1, op_b=0xFFFFFFFF.
- Instr 0x0040A183 (lw x3,4(x1)) then 0x003201B3 (add x3,x4,x3) back-to-back, out_ready=1 -> lw out; following cycle out_valid=0 (bubble); the add is accepted one cycle later.
- Instr 0xFE20CEE3 (blt x1,x2,-4) -> alu_op=LT, is_branch=1, imm=0xFFFFFFFC, reg_we=0; a branch with funct3=010 -> illegal=1.
- out_ready=0 for 3 cycles with an instruction held -> in_ready=0 and outputs stable; flush asserted -> out_valid=0 next cycle, input not consumed.
- Assert rst while out_valid=1 and flush=1 -> next cycle out_valid=0 and all outputs 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes a fetched instruction into ALU operation, operands and
// control flags, holding the result in a valid/ready output register.
module decode_stage #(
    parameter bit HAZARD_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  alu_op,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        use_cond,
    output logic [31:0] imm,
    output logic [31:0] store_data,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic [2:0]  mem_funct3,
    output logic        illegal
);

    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluSll = 4'd2;
    localparam logic [3:0] AluLt  = 4'd3;
    localparam logic [3:0] AluLtu = 4'd4;
    localparam logic [3:0] AluXor = 4'd5;
    localparam logic [3:0] AluSrl = 4'd6;
    localparam logic [3:0] AluSra = 4'd7;
    localparam logic [3:0] AluOr  = 4'd8;
    localparam logic [3:0] AluAnd = 4'd9;
    localparam logic [3:0] AluEq  = 4'd10;
    localparam logic [3:0] AluNe  = 4'd11;
    localparam logic [3:0] AluGe  = 4'd12;
    localparam logic [3:0] AluGeu = 4'd13;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic        use_cond;
        logic [31:0] imm;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic [2:0]  mem_funct3;
        logic        illegal;
    } dec_t;

    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluLt;
            3'b011:  return AluLtu;
            3'b100:  return AluXor;
            3'b101:  return AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_f;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] shamt;
    logic        uses_rs1, uses_rs2;
    logic        hazard, fire_in, fire_out;
    logic        legal, wb;
    dec_t        dec_d, dec_q;
    logic        out_valid_q;

    assign opcode   = in_instr[6:0];
    assign rd_f     = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign alt      = (funct7 == 7'h20);

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'd0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
    assign shamt = {27'd0, in_instr[24:20]};

    assign uses_rs1 = (opcode == OpcOp) || (opcode == OpcOpImm) || (opcode == OpcLoad) ||
                      (opcode == OpcStore) || (opcode == OpcBranch) || (opcode == OpcJalr);
    assign uses_rs2 = (opcode == OpcOp) || (opcode == OpcStore) || (opcode == OpcBranch);

    // Only the instruction sitting in the output register can be a load still in flight.
    assign hazard = HAZARD_CHECK && in_valid && out_valid_q && dec_q.is_load &&
                    (dec_q.rd != 5'd0) &&
                    ((uses_rs1 && (rs1_addr == dec_q.rd)) ||
                     (uses_rs2 && (rs2_addr == dec_q.rd)));

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid_q && out_ready;

    always_comb begin
        dec_d = '0;
        legal = 1'b1;
        wb    = 1'b0;
        case (opcode)
            OpcOp: begin
                wb                = 1'b1;
                dec_d.op_a        = rs1_data;
                dec_d.op_b        = rs2_data;
                dec_d.use_cond    = (funct3 == 3'b010) || (funct3 == 3'b011);
                legal             = (funct7 == 7'h00) ||
                                    (alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec_d.alu_op      = alt ? ((funct3 == 3'b000) ? AluSub : AluSra)
                                        : f3_alu(funct3);
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    dec_d.op_b = {27'd0, rs2_data[4:0]};
                end
            end
            OpcOpImm: begin
                wb             = 1'b1;
                dec_d.op_a     = rs1_data;
                dec_d.op_b     = imm_i;
                dec_d.imm      = imm_i;
                dec_d.use_cond = (funct3 == 3'b010) || (funct3 == 3'b011);
                dec_d.alu_op   = f3_alu(funct3);
                if (funct3 == 3'b001) begin
                    legal      = (funct7 == 7'h00);
                    dec_d.op_b = shamt;
                end else if (funct3 == 3'b101) begin
                    legal        = (funct7 == 7'h00) || alt;
                    dec_d.alu_op = alt ? AluSra : AluSrl;
                    dec_d.op_b   = shamt;
                end
            end
            OpcLui: begin
                wb         = 1'b1;
                dec_d.op_b = imm_u;
                dec_d.imm  = imm_u;
            end
            OpcAuipc: begin
                wb         = 1'b1;
                dec_d.op_a = in_pc;
                dec_d.op_b = imm_u;
                dec_d.imm  = imm_u;
            end
            OpcJal: begin
                wb           = 1'b1;
                dec_d.op_a   = in_pc;
                dec_d.op_b   = 32'd4;
                dec_d.imm    = imm_j;
                dec_d.is_jal = 1'b1;
            end
            OpcJalr: begin
                wb            = 1'b1;
                legal         = (funct3 == 3'b000);
                dec_d.op_a    = in_pc;
                dec_d.op_b    = 32'd4;
                dec_d.imm     = imm_i;
                dec_d.is_jalr = 1'b1;
            end
            OpcBranch: begin
                dec_d.op_a      = rs1_data;
                dec_d.op_b      = rs2_data;
                dec_d.imm       = imm_b;
                dec_d.is_branch = 1'b1;
                case (funct3)
                    3'b000:  dec_d.alu_op = AluEq;
                    3'b001:  dec_d.alu_op = AluNe;
                    3'b100:  dec_d.alu_op = AluLt;
                    3'b101:  dec_d.alu_op = AluGe;
                    3'b110:  dec_d.alu_op = AluLtu;
                    3'b111:  dec_d.alu_op = AluGeu;
                    default: legal = 1'b0;
                endcase
            end
            OpcLoad: begin
                wb            = 1'b1;
                dec_d.op_a    = rs1_data;
                dec_d.op_b    = imm_i;
                dec_d.imm     = imm_i;
                dec_d.is_load = 1'b1;
                legal         = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OpcStore: begin
                dec_d.op_a       = rs1_data;
                dec_d.op_b       = imm_s;
                dec_d.imm        = imm_s;
                dec_d.store_data = rs2_data;
                dec_d.is_store   = 1'b1;
                legal            = (funct3 <= 3'b010);
            end
            default: legal = 1'b0;
        endcase
        dec_d.reg_we = wb && (rd_f != 5'd0);
        // Illegal encodings travel down the pipe as inert instructions carrying only pc/rd.
        if (!legal) begin
            dec_d = '0;
        end
        dec_d.pc         = in_pc;
        dec_d.rd         = rd_f;
        dec_d.mem_funct3 = funct3;
        dec_d.illegal    = !legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (fire_in) begin
            out_valid_q <= 1'b1;
            dec_q       <= dec_d;
        end else if (fire_out) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = dec_q.pc;
    assign alu_op     = dec_q.alu_op;
    assign op_a       = dec_q.op_a;
    assign op_b       = dec_q.op_b;
    assign use_cond   = dec_q.use_cond;
    assign imm        = dec_q.imm;
    assign store_data = dec_q.store_data;
    assign rd         = dec_q.rd;
    assign reg_we     = dec_q.reg_we;
    assign is_load    = dec_q.is_load;
    assign is_store   = dec_q.is_store;
    assign is_branch  = dec_q.is_branch;
    assign is_jal     = dec_q.is_jal;
    assign is_jalr    = dec_q.is_jalr;
    assign mem_funct3 = dec_q.mem_funct3;
    assign illegal    = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-decoded RV32I vectors, load-use bubble, stall and flush.
module tb_decode_stage;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LT  = 4'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, op_a, op_b, imm, store_data;
    logic [3:0]  alu_op;
    logic        use_cond, reg_we, is_load, is_store, is_branch, is_jal, is_jalr, illegal;
    logic [4:0]  rd;
    logic [2:0]  mem_funct3;

    int n_vec = 0;
    int n_err = 0;

    decode_stage #(.HAZARD_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .use_cond(use_cond), .imm(imm),
        .store_data(store_data), .rd(rd), .reg_we(reg_we),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .mem_funct3(mem_funct3), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if ({alu_op, op_a, op_b, out_pc, rd, reg_we, illegal} !== '0) begin n_err++; $display("FAIL reset_outputs: got nonzero alu_op=%0d op_a=%h op_b=%h pc=%h", alu_op, op_a, op_b, out_pc); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, 32'h00208033, 32'h0000_0100, 32'd5, 32'd7);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        n_vec++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL add_rs_addr: got %0d/%0d want 1/2", rs1_addr, rs2_addr); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_vec++; if (alu_op !== ALU_ADD) begin n_err++; $display("FAIL add_alu_op: got %0d want %0d", alu_op, ALU_ADD); end
        n_vec++; if ({op_a, op_b} !== {32'd5, 32'd7}) begin n_err++; $display("FAIL add_operands: got %h/%h want 5/7", op_a, op_b); end
        n_vec++; if ({rd, reg_we} !== {5'd0, 1'b0}) begin n_err++; $display("FAIL add_rd_we: got rd=%0d we=%b want 0/0", rd, reg_we); end
        n_vec++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL add_pc: got %h want 100", out_pc); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_sra_slti();
        drive(1'b1, 32'h4020D1B3, 32'h104, 32'h8000_0000, 32'hFFFF_FF23);
        tick();
        n_vec++; if (alu_op !== ALU_SRA) begin n_err++; $display("FAIL sra_alu_op: got %0d want %0d", alu_op, ALU_SRA); end
        n_vec++; if ({op_a, op_b} !== {32'h8000_0000, 32'd3}) begin n_err++; $display("FAIL sra_operands: got %h/%h want 80000000/3", op_a, op_b); end
        n_vec++; if ({rd, reg_we, use_cond} !== {5'd3, 1'b1, 1'b0}) begin n_err++; $display("FAIL sra_ctrl: got rd=%0d we=%b uc=%b want 3/1/0", rd, reg_we, use_cond); end
        drive(1'b1, 32'hFFF0A193, 32'h108, 32'd9, 32'd0);
        tick();
        n_vec++; if ({alu_op, use_cond} !== {ALU_LT, 1'b1}) begin n_err++; $display("FAIL slti_op: got alu=%0d uc=%b want %0d/1", alu_op, use_cond, ALU_LT); end
        n_vec++; if ({op_a, op_b} !== {32'd9, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL slti_operands: got %h/%h want 9/ffffffff", op_a, op_b); end
        n_vec++; if ({reg_we, out_pc} !== {1'b1, 32'h108}) begin n_err++; $display("FAIL slti_we_pc: got %b/%h want 1/108", reg_we, out_pc); end
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h0040A183, 32'h200, 32'h1000, 32'd0);
        tick();
        n_vec++; if ({out_valid, is_load, alu_op} !== {1'b1, 1'b1, ALU_ADD}) begin n_err++; $display("FAIL lw_flags: got v=%b ld=%b alu=%0d want 1/1/0", out_valid, is_load, alu_op); end
        n_vec++; if ({op_a, op_b, mem_funct3} !== {32'h1000, 32'd4, 3'd2}) begin n_err++; $display("FAIL lw_fields: got %h/%h/%0d want 1000/4/2", op_a, op_b, mem_funct3); end
        n_vec++; if ({rd, reg_we} !== {5'd3, 1'b1}) begin n_err++; $display("FAIL lw_rd: got %0d/%b want 3/1", rd, reg_we); end
        drive(1'b1, 32'h003201B3, 32'h204, 32'd40, 32'd55);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hazard_ready: got %b want 0", in_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL after_bubble_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        n_vec++; if ({out_valid, is_load, out_pc} !== {1'b1, 1'b0, 32'h204}) begin n_err++; $display("FAIL dep_accept: got v=%b ld=%b pc=%h want 1/0/204", out_valid, is_load, out_pc); end
        n_vec++; if ({op_a, op_b, rd} !== {32'd40, 32'd55, 5'd3}) begin n_err++; $display("FAIL dep_fields: got %h/%h/%0d want 28/37/3", op_a, op_b, rd); end
        tick();
    endtask

    task automatic test_branch_misc();
        drive(1'b1, 32'hFE20CEE3, 32'h300, 32'd10, 32'd20);
        tick();
        n_vec++; if ({alu_op, is_branch, reg_we} !== {ALU_LT, 1'b1, 1'b0}) begin n_err++; $display("FAIL blt_ctrl: got alu=%0d br=%b we=%b want 3/1/0", alu_op, is_branch, reg_we); end
        n_vec++; if (imm !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL blt_imm: got %h want fffffffc", imm); end
        n_vec++; if ({op_a, op_b, illegal} !== {32'd10, 32'd20, 1'b0}) begin n_err++; $display("FAIL blt_operands: got %h/%h ill=%b want a/14/0", op_a, op_b, illegal); end
        drive(1'b1, 32'hFE20AEE3, 32'h304, 32'd10, 32'd20);
        tick();
        n_vec++; if ({out_valid, illegal} !== 2'b11) begin n_err++; $display("FAIL bad_branch_illegal: got v=%b ill=%b want 1/1", out_valid, illegal); end
        n_vec++; if ({alu_op, op_a, op_b, is_branch, reg_we} !== '0) begin n_err++; $display("FAIL bad_branch_zero: got alu=%0d a=%h b=%h br=%b", alu_op, op_a, op_b, is_branch); end
        n_vec++; if (out_pc !== 32'h304) begin n_err++; $display("FAIL bad_branch_pc: got %h want 304", out_pc); end
        drive(1'b1, 32'h0020A423, 32'h308, 32'h2000, 32'hCAFE_F00D);
        tick();
        n_vec++; if ({is_store, reg_we, op_a, op_b} !== {1'b1, 1'b0, 32'h2000, 32'd8}) begin n_err++; $display("FAIL sw_ctrl: got st=%b we=%b a=%h b=%h", is_store, reg_we, op_a, op_b); end
        n_vec++; if (store_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL sw_data: got %h want cafef00d", store_data); end
        drive(1'b1, 32'h008000EF, 32'h30C, 32'd0, 32'd0);
        tick();
        n_vec++; if ({is_jal, reg_we, rd, op_a, op_b, imm} !== {1'b1, 1'b1, 5'd1, 32'h30C, 32'd4, 32'd8}) begin n_err++; $display("FAIL jal: got j=%b we=%b rd=%0d a=%h b=%h imm=%h", is_jal, reg_we, rd, op_a, op_b, imm); end
        drive(1'b1, 32'h12345337, 32'h310, 32'd77, 32'd0);
        tick();
        n_vec++; if ({alu_op, op_a, op_b, rd} !== {ALU_ADD, 32'd0, 32'h1234_5000, 5'd6}) begin n_err++; $display("FAIL lui: got alu=%0d a=%h b=%h rd=%0d", alu_op, op_a, op_b, rd); end
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h400, 32'd1, 32'd2);
        tick();
        drive(1'b1, 32'h4020D1B3, 32'h404, 32'd99, 32'd98);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
            n_vec++; if ({out_valid, op_a, op_b, out_pc} !== {1'b1, 32'd1, 32'd2, 32'h400}) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b a=%h b=%h pc=%h", i, out_valid, op_a, op_b, out_pc); end
            tick();
        end
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_after_ready: got %b want 1", in_ready); end
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_rst_over_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h4020D1B3, 32'h500, 32'h55, 32'h66);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flush_valid: got %b want 0", out_valid); end
        n_vec++; if ({out_pc, alu_op, op_a, op_b, rd, reg_we, imm, use_cond} !== '0) begin n_err++; $display("FAIL rst_flush_zero: got pc=%h alu=%0d a=%h b=%h rd=%0d", out_pc, alu_op, op_a, op_b, rd); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sra_slti();
        test_load_use();
        test_branch_misc();
        test_stall_flush();
        test_rst_over_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
